z2_cycle_master: RTL and testbench
==================================

Name: z2_cycle_master

Overview:
- Zorro II / 68000-style bus initiator: turns a single-word request from on-card logic into one asynchronous bus cycle.
- Drives address, RW, AS_n, UDS_n, LDS_n and write data; waits for the target's DTACK_n.
- Returns read data, or flags a bus error on timeout.
- Counterpart of the card's Zorro II responder registers; used for self-test and for DMA-style transfers from the card.

Parameters:
- TIMEOUT, 64, CLK cycles from AS_n assertion to DTACK_n before the cycle aborts with req_berr; also bounds the recovery wait; minimum 4.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  single clock for the whole block.
- RESET  in  1  synchronous, active-high reset.
- req  in  1  start a cycle; sampled only in IDLE.
- req_rw  in  1  1 = read, 0 = write (68000 RW sense).
- req_addr  in  23  word address A[23:1].
- req_wdata  in  16  write data.
- req_uds  in  1  enable upper byte lane (D15:8).
- req_lds  in  1  enable lower byte lane (D7:0).
- busy  out  1  high from the cycle after req is accepted until the return to IDLE.
- req_ack  out  1  one-cycle completion pulse.
- req_rdata  out  16  captured read data; valid while req_ack=1, held until the next acceptance.
- req_berr  out  1  timeout/abort flag; valid while req_ack=1.
- ADDR  out  23  bus address A[23:1].
- RW  out  1  bus read/write.
- AS_n  out  1  address strobe.
- UDS_n  out  1  upper data strobe.
- LDS_n  out  1  lower data strobe.
- DOUT  out  16  bus write data.
- DOUT_OE  out  1  data output enable.
- DIN  in  16  bus read data.
- DTACK_n  in  1  asynchronous; two-flop synchronised internally to dtack_s (active-low).

Behaviour:
- All outputs registered.
- Reset values: AS_n=UDS_n=LDS_n=1, RW=1, DOUT_OE=0, ADDR=0, DOUT=0, busy=0, req_ack=0, req_berr=0, req_rdata=0, state=IDLE, counter=0, synchroniser flops=1.
- RESET mid-cycle: all strobes negate and DOUT_OE drops at that edge; no req_ack is issued.
- States: IDLE, SETUP, STROBE, WAIT, END, RECOVER.
- IDLE:
  - On req=1, latch rw/addr/wdata/lanes and go to SETUP.
  - If req_uds=req_lds=0, go directly to END with req_berr=1; no bus activity.
  - req while busy is ignored (not queued).
- SETUP (1 cycle):
  - ADDR and RW valid, AS_n=1.
  - DOUT=wdata with DOUT_OE=1 for writes.
- STROBE (1 cycle):
  - AS_n=0.
  - Read: enabled DS_n asserted in the same cycle.
  - Write: DS_n stay high (data setup before DS).
  - Counter cleared.
- WAIT:
  - AS_n=0 and the enabled DS_n low; counter increments each cycle.
  - First cycle with dtack_s=0: if read, capture DIN into req_rdata; go to END with berr=0.
  - If counter reaches TIMEOUT-1 with dtack_s still 1: go to END with berr=1; req_rdata unchanged.
  - If DTACK and timeout occur on the same cycle, DTACK wins (berr=0).
- END (1 cycle):
  - AS_n, UDS_n, LDS_n negate.
  - DOUT_OE stays 1 for writes (data hold); ADDR and RW held.
  - req_ack=1.
- RECOVER:
  - DOUT_OE=0, RW=1.
  - Wait until dtack_s=1, then go to IDLE.
  - Bounded by TIMEOUT cycles; on expiry, go to IDLE regardless. No second ack; berr is not changed.
- Minimum AS_n high time between back-to-back cycles: RECOVER + IDLE + SETUP ≥ 3 cycles.
- Latency with a responder whose dtack_s goes low on the k-th WAIT cycle: req_ack fires 3+k cycles after the req-sampling edge.

Test Plan:
- Read, responder drives DIN=16'hA55A and DTACK_n low 2 cycles after AS_n falls, releases it when AS_n rises:
  - req_rw=1, req_addr=23'h5F0000 -> ADDR=23'h5F0000, RW=1, UDS_n=LDS_n=0 with AS_n.
  - req_ack one pulse, req_rdata=16'hA55A, req_berr=0, busy back low after RECOVER.
- Write, req_wdata=16'h1234, lanes=10:
  - DOUT=16'h1234 and DOUT_OE=1 from SETUP through END.
  - UDS_n falls one cycle after AS_n; LDS_n stays high throughout.
  - RW=0 from SETUP through END.
- No DTACK, TIMEOUT=64:
  - req_berr=1 with req_ack exactly 64 WAIT cycles after STROBE; strobes negate.
  - req_rdata keeps its previous value.
- Lanes 00 -> req_ack in the cycle after acceptance with req_berr=1; AS_n never asserts.
- req pulsed during WAIT, then RESET asserted in WAIT:
  - The second req is ignored.
  - After RESET: AS_n=UDS_n=LDS_n=1, DOUT_OE=0, busy=0, no req_ack.
- Back-to-back reads with req held high: AS_n high for ≥3 cycles between cycles; two distinct req_ack pulses.

Source files
------------

// File: rtl/z2_cycle_master.sv
// Zorro II / 68000-style bus initiator: runs one asynchronous word cycle per request
// and returns read data, or flags a bus error when DTACK_n never arrives.
module z2_cycle_master #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        req_rw,
  input  logic [22:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_uds,
  input  logic        req_lds,
  output logic        busy,
  output logic        req_ack,
  output logic [15:0] req_rdata,
  output logic        req_berr,
  output logic [22:0] ADDR,
  output logic        RW,
  output logic        AS_n,
  output logic        UDS_n,
  output logic        LDS_n,
  output logic [15:0] DOUT,
  output logic        DOUT_OE,
  input  logic [15:0] DIN,
  input  logic        DTACK_n
);

  // state    | meaning
  // S_IDLE   | waiting for req
  // S_SETUP  | address/RW (and write data) valid, AS_n high
  // S_STROBE | AS_n asserted; read strobes DS with AS
  // S_WAIT   | strobes asserted, waiting for DTACK or timeout
  // S_END    | strobes negated, req_ack pulse, write data held
  // S_RECOVER| waiting for the target to release DTACK
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_END, S_RECOVER
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dtack_m, dtack_s;
  logic             cyc_rw, cyc_rw_nxt;
  logic             cyc_uds, cyc_uds_nxt;
  logic             cyc_lds, cyc_lds_nxt;

  logic        busy_nxt, ack_nxt, berr_nxt;
  logic [15:0] rdata_nxt, dout_nxt;
  logic [22:0] addr_nxt;
  logic        rw_nxt, as_nxt, uds_nxt, lds_nxt, oe_nxt;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cyc_rw_nxt  = cyc_rw;
    cyc_uds_nxt = cyc_uds;
    cyc_lds_nxt = cyc_lds;
    ack_nxt     = 1'b0;
    berr_nxt    = req_berr;
    rdata_nxt   = req_rdata;
    addr_nxt    = ADDR;
    rw_nxt      = RW;
    as_nxt      = AS_n;
    uds_nxt     = UDS_n;
    lds_nxt     = LDS_n;
    dout_nxt    = DOUT;
    oe_nxt      = DOUT_OE;

    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (!req_uds && !req_lds) begin
            // no lane enabled: abort without touching the bus
            state_nxt = S_END;
            ack_nxt   = 1'b1;
            berr_nxt  = 1'b1;
          end else begin
            state_nxt   = S_SETUP;
            cyc_rw_nxt  = req_rw;
            cyc_uds_nxt = req_uds;
            cyc_lds_nxt = req_lds;
            berr_nxt    = 1'b0;
            addr_nxt    = req_addr;
            rw_nxt      = req_rw;
            if (!req_rw) begin
              dout_nxt = req_wdata;
              oe_nxt   = 1'b1;
            end
          end
        end
      end
      S_SETUP: begin
        state_nxt = S_STROBE;
        cnt_nxt   = '0;
        as_nxt    = 1'b0;
        if (cyc_rw) begin
          uds_nxt = !cyc_uds;
          lds_nxt = !cyc_lds;
        end
      end
      S_STROBE: begin
        state_nxt = S_WAIT;
        uds_nxt   = !cyc_uds;
        lds_nxt   = !cyc_lds;
      end
      S_WAIT: begin
        if (!dtack_s || cnt == CNT_LAST) begin
          // DTACK takes priority over a coincident timeout
          state_nxt = S_END;
          ack_nxt   = 1'b1;
          berr_nxt  = dtack_s;
          cnt_nxt   = '0;
          as_nxt    = 1'b1;
          uds_nxt   = 1'b1;
          lds_nxt   = 1'b1;
          if (!dtack_s && cyc_rw) rdata_nxt = DIN;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_END: begin
        state_nxt = S_RECOVER;
        cnt_nxt   = '0;
        oe_nxt    = 1'b0;
        rw_nxt    = 1'b1;
      end
      S_RECOVER: begin
        if (dtack_s || cnt == CNT_LAST) state_nxt = S_IDLE;
        else                            cnt_nxt   = cnt + CNT_ONE;
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dtack_m   <= 1'b1;
      dtack_s   <= 1'b1;
      cyc_rw    <= 1'b1;
      cyc_uds   <= 1'b0;
      cyc_lds   <= 1'b0;
      busy      <= 1'b0;
      req_ack   <= 1'b0;
      req_berr  <= 1'b0;
      req_rdata <= '0;
      ADDR      <= '0;
      RW        <= 1'b1;
      AS_n      <= 1'b1;
      UDS_n     <= 1'b1;
      LDS_n     <= 1'b1;
      DOUT      <= '0;
      DOUT_OE   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dtack_m   <= DTACK_n;
      dtack_s   <= dtack_m;
      cyc_rw    <= cyc_rw_nxt;
      cyc_uds   <= cyc_uds_nxt;
      cyc_lds   <= cyc_lds_nxt;
      busy      <= busy_nxt;
      req_ack   <= ack_nxt;
      req_berr  <= berr_nxt;
      req_rdata <= rdata_nxt;
      ADDR      <= addr_nxt;
      RW        <= rw_nxt;
      AS_n      <= as_nxt;
      UDS_n     <= uds_nxt;
      LDS_n     <= lds_nxt;
      DOUT      <= dout_nxt;
      DOUT_OE   <= oe_nxt;
    end
  end

endmodule

// File: tb/tb_z2_cycle_master.sv
// Bench for z2_cycle_master: table of single cycles against a DTACK responder,
// plus back-to-back and reset-in-WAIT sequences.
module tb_z2_cycle_master;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req = 1'b0;
  logic        req_rw = 1'b1;
  logic [22:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_uds = 1'b0;
  logic        req_lds = 1'b0;
  logic        busy, req_ack, req_berr;
  logic [15:0] req_rdata;
  logic [22:0] ADDR;
  logic        RW, AS_n, UDS_n, LDS_n, DOUT_OE;
  logic [15:0] DOUT;
  logic [15:0] DIN = '0;
  logic        DTACK_n = 1'b1;

  z2_cycle_master #(.TIMEOUT(64), .CNT_W(7)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_uds(req_uds), .req_lds(req_lds), .busy(busy),
    .req_ack(req_ack), .req_rdata(req_rdata), .req_berr(req_berr), .ADDR(ADDR),
    .RW(RW), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .DOUT(DOUT),
    .DOUT_OE(DOUT_OE), .DIN(DIN), .DTACK_n(DTACK_n)
  );

  always #5 CLK = ~CLK;

  // responder: pulls DTACK_n low dly negedges after AS_n falls (0 = never), releases with AS_n
  int dly = 0;
  int as_cnt = 0;
  always @(negedge CLK) begin
    if (AS_n) begin
      as_cnt  = 0;
      DTACK_n = 1'b1;
    end else begin
      as_cnt++;
      if (dly != 0 && as_cnt == dly) DTACK_n = 1'b0;
    end
  end

  int    total = 0;
  int    bad = 0;
  string cur = "";

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %0h want %0h", cur, name, act, exp);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic        uds;
    logic        lds;
    logic [15:0] din;
    int          dly;
    int          lat;    // cycle index of req_ack, cycle 1 = SETUP
    logic        berr;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int ack_n, acks, as_fall, uds_fall, lds_fall, exp_u, exp_l;
    dly = v.dly;
    DIN = v.din;
    @(negedge CLK);
    req = 1'b1; req_rw = v.rw; req_addr = v.addr; req_wdata = v.wdata;
    req_uds = v.uds; req_lds = v.lds;
    @(posedge CLK); #1;
    req = 1'b0;
    ack_n = 0; acks = 0; as_fall = 0; uds_fall = 0; lds_fall = 0;
    for (int n = 1; n <= 150; n++) begin
      if (n == 1) chk("busy_start", 64'(busy), 64'(1));
      if (!AS_n && as_fall == 0) begin
        as_fall = n;
        chk("addr_rw", 64'({ADDR, RW}), 64'({v.addr, v.rw}));
        chk("ds_at_as", 64'({UDS_n, LDS_n}), v.rw ? 64'({!v.uds, !v.lds}) : 64'(2'b11));
      end
      if (!UDS_n && uds_fall == 0) uds_fall = n;
      if (!LDS_n && lds_fall == 0) lds_fall = n;
      if (req_ack) begin
        acks++;
        if (ack_n == 0) begin
          ack_n = n;
          chk("berr", 64'(req_berr), 64'(v.berr));
          chk("rdata", 64'(req_rdata), 64'(v.rdata));
          chk("strobes_end", 64'({AS_n, UDS_n, LDS_n}), 64'(3'b111));
        end
      end
      if (!v.rw && (ack_n == 0 || n == ack_n))
        chk("wr_drive", 64'({DOUT_OE, RW, DOUT}), 64'({1'b1, 1'b0, v.wdata}));
      if (!v.rw && ack_n != 0 && n == ack_n + 1)
        chk("wr_release", 64'({DOUT_OE, RW}), 64'(2'b01));
      if (ack_n != 0 && !busy) break;
      @(posedge CLK); #1;
    end
    chk("ack_lat", 64'(ack_n), 64'(v.lat));
    chk("ack_count", 64'(acks), 64'(1));
    chk("busy_end", 64'(busy), 64'(0));
    if (!v.uds && !v.lds) begin
      chk("no_as", 64'(as_fall), 64'(0));
    end else begin
      exp_u = v.uds ? as_fall + (v.rw ? 0 : 1) : 0;
      exp_l = v.lds ? as_fall + (v.rw ? 0 : 1) : 0;
      chk("uds_fall", 64'(uds_fall), 64'(exp_u));
      chk("lds_fall", 64'(lds_fall), 64'(exp_l));
    end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    int falls, run, gap, acks;
    logic prev;

    vecs[0] = '{rw:1'b1, addr:23'h5F0000, wdata:16'h0000, uds:1'b1, lds:1'b1,
                din:16'hA55A, dly:2, lat:6, berr:1'b0, rdata:16'hA55A};
    vecs[1] = '{rw:1'b0, addr:23'h000123, wdata:16'h1234, uds:1'b1, lds:1'b0,
                din:16'h5555, dly:2, lat:6, berr:1'b0, rdata:16'hA55A};
    vecs[2] = '{rw:1'b1, addr:23'h7FFFFF, wdata:16'h0000, uds:1'b0, lds:1'b1,
                din:16'h0F0F, dly:1, lat:5, berr:1'b0, rdata:16'h0F0F};
    vecs[3] = '{rw:1'b1, addr:23'h200000, wdata:16'h0000, uds:1'b1, lds:1'b1,
                din:16'hDEAD, dly:0, lat:67, berr:1'b1, rdata:16'h0F0F};
    vecs[4] = '{rw:1'b1, addr:23'h100000, wdata:16'h0000, uds:1'b0, lds:1'b0,
                din:16'h1111, dly:2, lat:1, berr:1'b1, rdata:16'h0F0F};
    vecs[5] = '{rw:1'b1, addr:23'h0ABCDE, wdata:16'h0000, uds:1'b1, lds:1'b1,
                din:16'hBEEF, dly:5, lat:9, berr:1'b0, rdata:16'hBEEF};

    cur = "reset";
    repeat (3) @(posedge CLK);
    #1;
    chk("ctrl", 64'({AS_n, UDS_n, LDS_n, RW, DOUT_OE, busy, req_ack, req_berr}), 64'(8'b1111_0000));
    chk("data", 64'({ADDR, DOUT, req_rdata}), 64'(0));
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 6; i++) begin
      cur = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end

    cur = "b2b";
    dly = 2;
    DIN = 16'h1357;
    @(negedge CLK);
    req = 1'b1; req_rw = 1'b1; req_addr = 23'h012345; req_uds = 1'b1; req_lds = 1'b1;
    @(posedge CLK); #1;
    falls = 0; run = 0; gap = 0; acks = 0; prev = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if (!AS_n && prev) begin
        falls++;
        if (falls == 2) begin
          gap = run;
          req = 1'b0;
        end
        run = 0;
      end
      if (AS_n) run++;
      prev = AS_n;
      if (req_ack) acks++;
      if (falls >= 2 && acks >= 2 && !busy) break;
      @(posedge CLK); #1;
    end
    req = 1'b0;
    chk("as_falls", 64'(falls), 64'(2));
    chk("acks", 64'(acks), 64'(2));
    chk("as_gap_ge3", 64'(gap >= 3), 64'(1));
    chk("rdata", 64'(req_rdata), 64'(16'h1357));
    repeat (2) @(posedge CLK);
    #1;

    cur = "reset_in_wait";
    dly = 0;
    @(negedge CLK);
    req = 1'b1; req_rw = 1'b0; req_addr = 23'h333333; req_wdata = 16'hCAFE;
    req_uds = 1'b1; req_lds = 1'b1;
    @(posedge CLK); #1;
    req = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    req = 1'b1; req_rw = 1'b1; req_addr = 23'h444444;
    @(posedge CLK); #1;
    req = 1'b0;
    chk("still_wait", 64'({AS_n, UDS_n, LDS_n, busy, req_ack}), 64'(5'b00010));
    chk("2nd_req_ignored", 64'({ADDR, DOUT, DOUT_OE}), 64'({23'h333333, 16'hCAFE, 1'b1}));
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("after_reset", 64'({AS_n, UDS_n, LDS_n, DOUT_OE, busy, req_ack}), 64'(6'b111000));
    @(negedge CLK);
    RESET = 1'b0;
    acks = 0;
    run = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge CLK); #1;
      if (req_ack) acks++;
      if (busy || !AS_n) run++;
    end
    chk("no_ack_after_reset", 64'(acks), 64'(0));
    chk("idle_after_reset", 64'(run), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
